jtag_tap_ir: RTL and testbench

Parametrised JTAG front end combining the IEEE 1149.1 16-state TAP controller with a generic-length instruction register, instruction decoder and TDO output stage. It drives the TAP strobes consumed by the data-register blocks (boundary scan, IDCODE, bypass, user DRs) and muxes their serial outputs onto TDO. It adds configurable IR length, capture pattern, reset instruction and a bank of user instruction selects.

---
 rtl/jtag_tap_ir.sv | 143 ++++++++++++++
 tb/tb_jtag_tap_ir.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_ir.sv
// IEEE 1149.1 TAP controller with a parameterised instruction register, instruction
// decoder and negedge TDO stage. TAP_STATE exposes the controller state directly.
module jtag_tap_ir #(
  parameter int                IR_LEN      = 4,
  parameter logic [IR_LEN-1:0] CAPTURE_PAT = IR_LEN'('b0101),
  parameter logic [IR_LEN-1:0] IDCODE_OP   = IR_LEN'(7),
  parameter logic [IR_LEN-1:0] SAMPLE_OP   = IR_LEN'(1),
  parameter logic [IR_LEN-1:0] EXTEST_OP   = IR_LEN'(2),
  parameter logic [IR_LEN-1:0] INTEST_OP   = IR_LEN'(3),
  parameter logic [IR_LEN-1:0] RUNBIST_OP  = IR_LEN'(4),
  parameter logic [IR_LEN-1:0] CLAMP_OP    = IR_LEN'(5),
  parameter logic [IR_LEN-1:0] USERCODE_OP = IR_LEN'(8),
  parameter logic [IR_LEN-1:0] HIGHZ_OP    = IR_LEN'(9),
  parameter int                NUM_USER    = 4,
  parameter logic [IR_LEN-1:0] USER_BASE   = IR_LEN'('hA)
) (
  input  logic                TCK,
  input  logic                rst_n,
  input  logic                TMS,
  input  logic                TDI,
  input  logic                DR_TDO,
  output logic                TDO,
  output logic                TDO_EN,
  output logic [3:0]          TAP_STATE,
  output logic                TLR,
  output logic                RTI,
  output logic                CAPTUREDR,
  output logic                SHIFTDR,
  output logic                UPDATEDR,
  output logic [IR_LEN-1:0]   LATCH_JTAG_IR,
  output logic                BYPASS_SELECT,
  output logic                SAMPLE_SELECT,
  output logic                EXTEST_SELECT,
  output logic                INTEST_SELECT,
  output logic                RUNBIST_SELECT,
  output logic                CLAMP_SELECT,
  output logic                IDCODE_SELECT,
  output logic                USERCODE_SELECT,
  output logic                HIGHZ_SELECT,
  output logic [NUM_USER-1:0] USER_SELECT
);

  typedef enum logic [3:0] {
    ST_TLR     = 4'hF, ST_RTI     = 4'hC, ST_SEL_DR  = 4'h7, ST_CAP_DR  = 4'h6,
    ST_SH_DR   = 4'h2, ST_EX1_DR  = 4'h1, ST_PAU_DR  = 4'h3, ST_EX2_DR  = 4'h0,
    ST_UPD_DR  = 4'h5, ST_SEL_IR  = 4'h4, ST_CAP_IR  = 4'hE, ST_SH_IR   = 4'hA,
    ST_EX1_IR  = 4'h9, ST_PAU_IR  = 4'hB, ST_EX2_IR  = 4'h8, ST_UPD_IR  = 4'hD
  } tap_state_e;

  tap_state_e          state;
  tap_state_e          state_nxt;
  logic [IR_LEN-1:0]   ir_sr;
  logic [NUM_USER-1:0] user_hit;

  always_ff @(posedge TCK or negedge rst_n) begin
    if (!rst_n) state <= ST_TLR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_TLR:    state_nxt = TMS ? ST_TLR    : ST_RTI;
      ST_RTI:    state_nxt = TMS ? ST_SEL_DR : ST_RTI;
      ST_SEL_DR: state_nxt = TMS ? ST_SEL_IR : ST_CAP_DR;
      ST_CAP_DR: state_nxt = TMS ? ST_EX1_DR : ST_SH_DR;
      ST_SH_DR:  state_nxt = TMS ? ST_EX1_DR : ST_SH_DR;
      ST_EX1_DR: state_nxt = TMS ? ST_UPD_DR : ST_PAU_DR;
      ST_PAU_DR: state_nxt = TMS ? ST_EX2_DR : ST_PAU_DR;
      ST_EX2_DR: state_nxt = TMS ? ST_UPD_DR : ST_SH_DR;
      ST_UPD_DR: state_nxt = TMS ? ST_SEL_DR : ST_RTI;
      ST_SEL_IR: state_nxt = TMS ? ST_TLR    : ST_CAP_IR;
      ST_CAP_IR: state_nxt = TMS ? ST_EX1_IR : ST_SH_IR;
      ST_SH_IR:  state_nxt = TMS ? ST_EX1_IR : ST_SH_IR;
      ST_EX1_IR: state_nxt = TMS ? ST_UPD_IR : ST_PAU_IR;
      ST_PAU_IR: state_nxt = TMS ? ST_EX2_IR : ST_PAU_IR;
      ST_EX2_IR: state_nxt = TMS ? ST_UPD_IR : ST_SH_IR;
      ST_UPD_IR: state_nxt = TMS ? ST_SEL_DR : ST_RTI;
      default:   state_nxt = ST_TLR;
    endcase
  end

  assign TAP_STATE = state;
  assign TLR       = (state == ST_TLR);
  assign RTI       = (state == ST_RTI);
  assign CAPTUREDR = (state == ST_CAP_DR);
  assign SHIFTDR   = (state == ST_SH_DR);
  assign UPDATEDR  = (state == ST_UPD_DR);

  // Pause/Exit states fall through to hold, so an interrupted IR scan resumes intact.
  always_ff @(posedge TCK or negedge rst_n) begin
    if (!rst_n)                 ir_sr <= CAPTURE_PAT;
    else if (state == ST_CAP_IR) ir_sr <= CAPTURE_PAT;
    else if (state == ST_SH_IR)  ir_sr <= {TDI, ir_sr[IR_LEN-1:1]};
  end

  // Instruction and TDO change on the falling edge, half a TCK after the state moves.
  always_ff @(negedge TCK or negedge rst_n) begin
    if (!rst_n) begin
      LATCH_JTAG_IR <= IDCODE_OP;
      TDO           <= 1'b0;
      TDO_EN        <= 1'b0;
    end else begin
      if (state == ST_UPD_IR)   LATCH_JTAG_IR <= ir_sr;
      else if (state == ST_TLR) LATCH_JTAG_IR <= IDCODE_OP;
      case (state)
        ST_SH_IR: begin TDO <= ir_sr[0]; TDO_EN <= 1'b1; end
        ST_SH_DR: begin TDO <= DR_TDO;   TDO_EN <= 1'b1; end
        default:  begin TDO <= 1'b0;     TDO_EN <= 1'b0; end
      endcase
    end
  end

  always_comb begin
    user_hit        = '0;
    BYPASS_SELECT   = 1'b0;
    SAMPLE_SELECT   = 1'b0;
    EXTEST_SELECT   = 1'b0;
    INTEST_SELECT   = 1'b0;
    RUNBIST_SELECT  = 1'b0;
    CLAMP_SELECT    = 1'b0;
    IDCODE_SELECT   = 1'b0;
    USERCODE_SELECT = 1'b0;
    HIGHZ_SELECT    = 1'b0;
    USER_SELECT     = '0;
    for (int k = 0; k < NUM_USER; k++) begin
      if (LATCH_JTAG_IR == USER_BASE + IR_LEN'(k)) user_hit[k] = 1'b1;
    end
    // Priority chain keeps the selects one-hot even if opcodes overlap.
    if      (LATCH_JTAG_IR == IDCODE_OP)   IDCODE_SELECT   = 1'b1;
    else if (LATCH_JTAG_IR == SAMPLE_OP)   SAMPLE_SELECT   = 1'b1;
    else if (LATCH_JTAG_IR == EXTEST_OP)   EXTEST_SELECT   = 1'b1;
    else if (LATCH_JTAG_IR == INTEST_OP)   INTEST_SELECT   = 1'b1;
    else if (LATCH_JTAG_IR == RUNBIST_OP)  RUNBIST_SELECT  = 1'b1;
    else if (LATCH_JTAG_IR == CLAMP_OP)    CLAMP_SELECT    = 1'b1;
    else if (LATCH_JTAG_IR == USERCODE_OP) USERCODE_SELECT = 1'b1;
    else if (LATCH_JTAG_IR == HIGHZ_OP)    HIGHZ_SELECT    = 1'b1;
    else if (&LATCH_JTAG_IR)               BYPASS_SELECT   = 1'b1;
    else if (|user_hit)                    USER_SELECT     = user_hit;
    else                                   BYPASS_SELECT   = 1'b1;
  end

endmodule

// File: tb/tb_jtag_tap_ir.sv
// Bench for jtag_tap_ir: default 4-bit IR instance driven against a TAP model,
// plus an 8-bit IR instance exercising the parameter overrides.
module tb_jtag_tap_ir;

  localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_CAPDR = 4'h6, S_SHDR = 4'h2;
  localparam logic [3:0] S_PAUDR = 4'h3, S_UPDDR = 4'h5, S_CAPIR = 4'hE, S_SHIR = 4'hA;
  localparam logic [3:0] S_UPDIR = 4'hD;
  localparam logic [3:0] CAP4 = 4'b0101;

  // clock / reset
  logic TCK = 1'b0;
  logic rst_n = 1'b0;
  always #5 TCK = ~TCK;

  logic TMS = 1'b1, TDI = 1'b0, DR_TDO = 1'b0;
  logic tms8 = 1'b1, tdi8 = 1'b0;

  logic TDO, TDO_EN, TLR, RTI, CAPTUREDR, SHIFTDR, UPDATEDR;
  logic [3:0] TAP_STATE, LATCH_JTAG_IR, USER_SELECT;
  logic BYPASS_SELECT, SAMPLE_SELECT, EXTEST_SELECT, INTEST_SELECT, RUNBIST_SELECT;
  logic CLAMP_SELECT, IDCODE_SELECT, USERCODE_SELECT, HIGHZ_SELECT;
  logic [12:0] sel_vec;
  assign sel_vec = {BYPASS_SELECT, SAMPLE_SELECT, EXTEST_SELECT, INTEST_SELECT, RUNBIST_SELECT,
                    CLAMP_SELECT, IDCODE_SELECT, USERCODE_SELECT, HIGHZ_SELECT, USER_SELECT};

  logic tdo_8, tdo_en_8, tlr_8, rti_8, capdr_8, shdr_8, upddr_8;
  logic [3:0] state_8, user_8;
  logic [7:0] latch_8;
  logic byp_8, smp_8, ext_8, int_8, rbist_8, clamp_8, idc_8, uc_8, hz_8;

  jtag_tap_ir dut (
    .TCK(TCK), .rst_n(rst_n), .TMS(TMS), .TDI(TDI), .DR_TDO(DR_TDO),
    .TDO(TDO), .TDO_EN(TDO_EN), .TAP_STATE(TAP_STATE), .TLR(TLR), .RTI(RTI),
    .CAPTUREDR(CAPTUREDR), .SHIFTDR(SHIFTDR), .UPDATEDR(UPDATEDR),
    .LATCH_JTAG_IR(LATCH_JTAG_IR), .BYPASS_SELECT(BYPASS_SELECT),
    .SAMPLE_SELECT(SAMPLE_SELECT), .EXTEST_SELECT(EXTEST_SELECT),
    .INTEST_SELECT(INTEST_SELECT), .RUNBIST_SELECT(RUNBIST_SELECT),
    .CLAMP_SELECT(CLAMP_SELECT), .IDCODE_SELECT(IDCODE_SELECT),
    .USERCODE_SELECT(USERCODE_SELECT), .HIGHZ_SELECT(HIGHZ_SELECT),
    .USER_SELECT(USER_SELECT)
  );

  jtag_tap_ir #(.IR_LEN(8), .CAPTURE_PAT(8'h01), .USER_BASE(8'h80)) dut8 (
    .TCK(TCK), .rst_n(rst_n), .TMS(tms8), .TDI(tdi8), .DR_TDO(DR_TDO),
    .TDO(tdo_8), .TDO_EN(tdo_en_8), .TAP_STATE(state_8), .TLR(tlr_8), .RTI(rti_8),
    .CAPTUREDR(capdr_8), .SHIFTDR(shdr_8), .UPDATEDR(upddr_8),
    .LATCH_JTAG_IR(latch_8), .BYPASS_SELECT(byp_8), .SAMPLE_SELECT(smp_8),
    .EXTEST_SELECT(ext_8), .INTEST_SELECT(int_8), .RUNBIST_SELECT(rbist_8),
    .CLAMP_SELECT(clamp_8), .IDCODE_SELECT(idc_8), .USERCODE_SELECT(uc_8),
    .HIGHZ_SELECT(hz_8), .USER_SELECT(user_8)
  );

  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];
  logic [0:0] exp8_q[$];
  logic [3:0] m_state = S_TLR;
  logic [3:0] m_sr = CAP4;
  logic [3:0] m_latch = 4'h7;
  logic [7:0] tdo_log;
  int tdo_cnt;
  int cnt8;

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic tms);
    case (s)
      4'hF: return tms ? 4'hF : 4'hC;
      4'hC: return tms ? 4'h7 : 4'hC;
      4'h7: return tms ? 4'h4 : 4'h6;
      4'h6: return tms ? 4'h1 : 4'h2;
      4'h2: return tms ? 4'h1 : 4'h2;
      4'h1: return tms ? 4'h5 : 4'h3;
      4'h3: return tms ? 4'h0 : 4'h3;
      4'h0: return tms ? 4'h5 : 4'h2;
      4'h5: return tms ? 4'h7 : 4'hC;
      4'h4: return tms ? 4'hF : 4'hE;
      4'hE: return tms ? 4'h9 : 4'hA;
      4'hA: return tms ? 4'h9 : 4'hA;
      4'h9: return tms ? 4'hD : 4'hB;
      4'hB: return tms ? 4'h8 : 4'hB;
      4'h8: return tms ? 4'hD : 4'hA;
      default: return tms ? 4'h7 : 4'hC;
    endcase
  endfunction

  // {BYPASS,SAMPLE,EXTEST,INTEST,RUNBIST,CLAMP,IDCODE,USERCODE,HIGHZ,USER[3:0]}
  function automatic logic [12:0] exp_dec(input logic [3:0] op);
    case (op)
      4'h1: return 13'h0800;  4'h2: return 13'h0400;  4'h3: return 13'h0200;
      4'h4: return 13'h0100;  4'h5: return 13'h0080;  4'h7: return 13'h0040;
      4'h8: return 13'h0020;  4'h9: return 13'h0010;  4'hA: return 13'h0001;
      4'hB: return 13'h0002;  4'hC: return 13'h0004;  4'hD: return 13'h0008;
      default: return 13'h1000;
    endcase
  endfunction

  // driver: one TCK cycle on the 4-bit instance; model pushes TDO expectations
  task automatic tap_step(input logic tms, input logic tdi, input logic dr);
    logic [3:0] ns;
    logic       exp_en;
    logic [0:0] exp_bit;
    TMS = tms; TDI = tdi; DR_TDO = dr;
    ns = tap_next(m_state, tms);
    if (m_state == S_CAPIR)     m_sr = CAP4;
    else if (m_state == S_SHIR) m_sr = {tdi, m_sr[3:1]};
    m_state = ns;
    if (ns == S_UPDIR)    m_latch = m_sr;
    else if (ns == S_TLR) m_latch = 4'h7;
    exp_en = (ns == S_SHIR) || (ns == S_SHDR);
    if (exp_en) exp_q.push_back((ns == S_SHIR) ? m_sr[0] : dr);
    @(posedge TCK); #1;
    checks++;
    if (TAP_STATE !== m_state) begin
      errors++; $display("FAIL tap_state: got %h want %h", TAP_STATE, m_state);
    end
    @(negedge TCK); #1;
    checks++;
    if (TDO_EN !== exp_en) begin
      errors++; $display("FAIL tdo_en: got %b want %b (state %h)", TDO_EN, exp_en, m_state);
      if (exp_en) exp_bit = exp_q.pop_front();
    end
    checks++;
    if (TDO_EN === 1'b1) begin
      if (tdo_cnt < 8) tdo_log[tdo_cnt] = TDO;
      tdo_cnt++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL tdo_unexpected: got %b want nothing", TDO);
      end else begin
        exp_bit = exp_q.pop_front();
        if (TDO !== exp_bit) begin
          errors++; $display("FAIL tdo: got %b want %b (state %h)", TDO, exp_bit, m_state);
        end
      end
    end else if (TDO !== 1'b0) begin
      errors++; $display("FAIL tdo_idle: got %b want 0", TDO);
    end
    checks++;
    if (LATCH_JTAG_IR !== m_latch) begin
      errors++; $display("FAIL latch_ir: got %h want %h", LATCH_JTAG_IR, m_latch);
    end
  endtask

  // from RTI: scan val into the IR (optional pause after bit pause_at), update, back to RTI
  task automatic load_ir(input logic [3:0] val, input int pause_at);
    tdo_cnt = 0; tdo_log = '0;
    tap_step(1, 0, 0); tap_step(1, 0, 0); tap_step(0, 0, 0); tap_step(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tap_step((i == 3) || (i == pause_at), val[i], 0);
      if (i == pause_at && i != 3) begin
        tap_step(0, 0, 0); tap_step(0, 0, 0); tap_step(1, 0, 0); tap_step(0, 0, 0);
      end
    end
    tap_step(1, 0, 0);
    tap_step(0, 0, 0);
  endtask

  task automatic step8(input logic tms, input logic tdi);
    logic [0:0] exp_bit;
    tms8 = tms; tdi8 = tdi;
    @(posedge TCK); #1;
    @(negedge TCK); #1;
    if (tdo_en_8 === 1'b1) begin
      cnt8++;
      checks++;
      if (exp8_q.size() == 0) begin
        errors++; $display("FAIL ir8_tdo_unexpected: got %b want nothing", tdo_8);
      end else begin
        exp_bit = exp8_q.pop_front();
        if (tdo_8 !== exp_bit) begin
          errors++; $display("FAIL ir8_tdo: got %b want %b", tdo_8, exp_bit);
        end
      end
    end
  endtask

  task automatic test_reset();
    tap_step(0, 0, 0);
    tap_step(1, 0, 0); tap_step(1, 0, 0); tap_step(0, 0, 0); tap_step(0, 0, 0);
    tap_step(0, 1, 0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (TAP_STATE !== S_TLR || LATCH_JTAG_IR !== 4'h7 || IDCODE_SELECT !== 1'b1 ||
        TDO_EN !== 1'b0 || TDO !== 1'b0 || TLR !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: got st=%h ir=%h idc=%b en=%b tdo=%b want F 7 1 0 0",
               TAP_STATE, LATCH_JTAG_IR, IDCODE_SELECT, TDO_EN, TDO);
    end
    @(posedge TCK); #1;
    @(negedge TCK); #1;
    rst_n = 1'b1;
    m_state = S_TLR; m_sr = CAP4; m_latch = 4'h7;
    exp_q.delete();
    tap_step(1, 0, 0);
    checks++;
    if (IDCODE_SELECT !== 1'b1) begin
      errors++; $display("FAIL reset_release_idcode: got %b want 1", IDCODE_SELECT);
    end
    tap_step(0, 0, 0);
  endtask

  task automatic test_extest();
    load_ir(4'h2, -1);
    checks++;
    if (EXTEST_SELECT !== 1'b1 || sel_vec !== 13'h0400) begin
      errors++; $display("FAIL extest_select: got %h want %h", sel_vec, 13'h0400);
    end
    checks++;
    if (tdo_cnt != 4 || tdo_log[3:0] !== 4'b0101) begin
      errors++; $display("FAIL extest_capture: got %0d bits %b want 4 bits 0101", tdo_cnt, tdo_log[3:0]);
    end
  endtask

  task automatic test_bypass();
    load_ir(4'hF, -1);
    checks++;
    if (BYPASS_SELECT !== 1'b1 || sel_vec !== 13'h1000) begin
      errors++; $display("FAIL bypass_ones: got %h want %h", sel_vec, 13'h1000);
    end
    load_ir(4'h6, -1);
    checks++;
    if (BYPASS_SELECT !== 1'b1 || sel_vec !== 13'h1000) begin
      errors++; $display("FAIL bypass_unmatched: got %h want %h", sel_vec, 13'h1000);
    end
    load_ir(4'hB, -1);
    checks++;
    if (USER_SELECT !== 4'b0010 || sel_vec !== 13'h0002) begin
      errors++; $display("FAIL user1: got %h want %h", sel_vec, 13'h0002);
    end
  endtask

  task automatic test_ir_pause();
    load_ir(4'h3, 1);
    checks++;
    if (INTEST_SELECT !== 1'b1 || LATCH_JTAG_IR !== 4'h3) begin
      errors++; $display("FAIL ir_pause: got ir=%h intest=%b want 3 1", LATCH_JTAG_IR, INTEST_SELECT);
    end
    checks++;
    if (tdo_cnt != 4 || tdo_log[3:0] !== 4'b0101) begin
      errors++; $display("FAIL ir_pause_capture: got %0d bits %b want 4 bits 0101", tdo_cnt, tdo_log[3:0]);
    end
  endtask

  task automatic test_dr_pause();
    tap_step(1, 0, 0);
    tap_step(0, 0, 0);
    checks++;
    if (CAPTUREDR !== 1'b1) begin errors++; $display("FAIL capturedr: got %b want 1", CAPTUREDR); end
    tap_step(0, 0, 1);
    checks++;
    if (SHIFTDR !== 1'b1 || TDO !== 1'b1) begin
      errors++; $display("FAIL shiftdr: got sh=%b tdo=%b want 1 1", SHIFTDR, TDO);
    end
    tap_step(0, 0, 0); tap_step(0, 0, 1);
    tap_step(1, 0, 0);
    tap_step(0, 0, 1);
    checks++;
    if (TAP_STATE !== S_PAUDR || TDO_EN !== 1'b0 || TDO !== 1'b0) begin
      errors++; $display("FAIL pausedr: got st=%h en=%b tdo=%b want 3 0 0", TAP_STATE, TDO_EN, TDO);
    end
    tap_step(0, 0, 1); tap_step(1, 0, 0);
    tap_step(0, 0, 0); tap_step(0, 0, 1); tap_step(0, 0, 1);
    tap_step(1, 0, 0); tap_step(1, 0, 0);
    checks++;
    if (UPDATEDR !== 1'b1 || TAP_STATE !== S_UPDDR) begin
      errors++; $display("FAIL updatedr: got %b st=%h want 1 5", UPDATEDR, TAP_STATE);
    end
    tap_step(0, 0, 0);
    checks++;
    if (RTI !== 1'b1) begin errors++; $display("FAIL rti: got %b want 1", RTI); end
  endtask

  task automatic test_random_decode();
    logic [3:0] op;
    int pause;
    for (int n = 0; n < 10; n++) begin
      op = 4'($urandom_range(0, 15));
      pause = int'($urandom_range(0, 4)) - 1;
      load_ir(op, pause);
      checks++;
      if (sel_vec !== exp_dec(op) || $countones(sel_vec) != 1) begin
        errors++; $display("FAIL decode_%h: got %h want %h", op, sel_vec, exp_dec(op));
      end
    end
  endtask

  task automatic test_tlr_from_shir();
    load_ir(4'h9, -1);
    checks++;
    if (HIGHZ_SELECT !== 1'b1) begin errors++; $display("FAIL highz: got %b want 1", HIGHZ_SELECT); end
    tap_step(1, 0, 0); tap_step(1, 0, 0); tap_step(0, 0, 0); tap_step(0, 0, 0);
    for (int i = 0; i < 5; i++) tap_step(1, 0, 0);
    checks++;
    if (TLR !== 1'b1 || LATCH_JTAG_IR !== 4'h7 || IDCODE_SELECT !== 1'b1) begin
      errors++; $display("FAIL tlr_from_shir: got tlr=%b ir=%h want 1 7", TLR, LATCH_JTAG_IR);
    end
    tap_step(0, 0, 0);
  endtask

  task automatic test_five_ones();
    int len;
    for (int n = 0; n < 6; n++) begin
      len = int'($urandom_range(3, 14));
      for (int i = 0; i < len; i++)
        tap_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 5; i++) tap_step(1, 0, 0);
      checks++;
      if (TAP_STATE !== S_TLR) begin
        errors++; $display("FAIL five_ones_%0d: got %h want F", n, TAP_STATE);
      end
      tap_step(0, 0, 0);
    end
  endtask

  task automatic test_ir8();
    logic [7:0] val = 8'h81;
    cnt8 = 0;
    step8(0, 0);
    checks++;
    if (state_8 !== S_RTI) begin errors++; $display("FAIL ir8_rti: got %h want C", state_8); end
    step8(1, 0); step8(1, 0); step8(0, 0);
    exp8_q.push_back(1'b1);
    for (int i = 0; i < 7; i++) exp8_q.push_back(1'b0);
    step8(0, 0);
    for (int i = 0; i < 8; i++) step8(i == 7, val[i]);
    step8(1, 0);
    checks++;
    if (latch_8 !== 8'h81 || user_8 !== 4'b0010 || byp_8 !== 1'b0) begin
      errors++; $display("FAIL ir8_user1: got ir=%h user=%b byp=%b want 81 0010 0", latch_8, user_8, byp_8);
    end
    checks++;
    if (cnt8 != 8 || exp8_q.size() != 0) begin
      errors++; $display("FAIL ir8_bits: got %0d left %0d want 8 left 0", cnt8, exp8_q.size());
    end
    step8(0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge TCK);
    #1;
    checks++;
    if (TAP_STATE !== S_TLR || LATCH_JTAG_IR !== 4'h7 || TDO_EN !== 1'b0 || TDO !== 1'b0) begin
      errors++; $display("FAIL por: got st=%h ir=%h en=%b tdo=%b want F 7 0 0",
                         TAP_STATE, LATCH_JTAG_IR, TDO_EN, TDO);
    end
    rst_n = 1'b1;
    test_reset();
    test_extest();
    test_bypass();
    test_ir_pause();
    test_dr_pause();
    test_random_decode();
    test_tlr_from_shir();
    test_five_ones();
    test_ir8();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
